// File: rtl/shifter_iter.sv
// Iterative shifter: SLL/SRL/SRA/ROR, at most STEP bits per cycle.
// Ports: clk, rst_n, flush, in_valid/in_ready, op, a, shamt, out_valid/out_ready, result, busy.
module shifter_iter #(
  parameter  int XLEN = 32,
  parameter  int STEP = 4,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
  localparam logic [SHW:0] XW     = (SHW+1)'(XLEN);

  state_t          state;
  logic [XLEN-1:0] data;
  logic [1:0]      opr;
  logic [SHW-1:0]  rem;

  logic [SHW:0]    k;
  logic [XLEN-1:0] shd;

  // k never exceeds rem, so it never reaches XLEN
  always_comb begin
    k   = ({1'b0, rem} >= STEP_W) ? STEP_W : {1'b0, rem};
    shd = data;
    unique case (opr)
      2'b00: shd = data << k;
      2'b01: shd = data >> k;
      2'b10: shd = XLEN'($signed(data) >>> k);
      2'b11: shd = (data >> k) | (data << (XW - k));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      opr   <= 2'b00;
      rem   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= a;
            opr   <= op;
            rem   <= shamt;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rem != '0) begin
            data <= shd;
            rem  <= rem - k[SHW-1:0];
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = data;

endmodule

// File: tb/tb_shifter_iter.sv
// Bench for shifter_iter (XLEN=32, STEP=4).
// Scoreboard queue of expected results, popped on output handshake.
module tb_shifter_iter;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  shifter_iter #(
    .XLEN(32),
    .STEP(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .shamt(shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [4:0] s);
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return 32'($signed(x) >>> s);
      default: return (s == 0) ? x
                 : ((x >> s) | (x << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  function automatic int lat(input logic [4:0] s);
    return (int'(s) + STEP - 1) / STEP + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else chk("result", result, sb.pop_front());
    end
  end

  task automatic start(input logic [1:0] o, input logic [31:0] x,
                       input logic [4:0] s, input bit push);
    bit rdy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        rdy = 1;
        break;
      end
    end
    if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    shamt = s;
    @(posedge clk);
    if (push) sb.push_back(model(o, x, s));
    #1;
    in_valid = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    shamt = 5'($urandom);
  endtask

  task automatic wait_valid(input int exp_lat);
    int n = 0;
    while (n <= 20) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk("latency", n, exp_lat);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x,
                     input logic [4:0] s);
    start(o, x, s, 1);
    wait_valid(lat(s));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r0;
    int seen;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    run(2'b00, 32'h0000_0005, 5'd2);
    run(2'b10, 32'hFFFF_F000, 5'd4);
    run(2'b01, 32'hFFFF_F000, 5'd31);
    run(2'b11, 32'h0000_0001, 5'd1);
    for (int o = 0; o < 4; o++) run(2'(o), 32'h1234_5678, 5'd0);

    // output held while consumer stalls
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start(2'b10, 32'h8000_0010, 5'd7, 1);
    wait_valid(3);
    r0 = result;
    chk("hold_first", r0, 32'hFF00_0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = $urandom;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, r0);
      chk("hold_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("no_same_cycle_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after", in_ready, 1);

    // flush in second busy cycle
    start(2'b01, 32'hFFFF_F000, 5'd31, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("flush_no_valid", seen, 0);
    run(2'b01, 32'hFFFF_F000, 5'd31);

    // async reset mid-operation
    start(2'b00, 32'h0000_1234, 5'd20, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("rst_no_valid", seen, 0);
    run(2'b00, 32'h0000_0001, 5'd31);

    for (int i = 0; i < 12; i++) begin
      run(2'($urandom), $urandom, 5'($urandom));
    end

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shifter_iter.md
SHIFTER_ITER -- requirements
Module: shifter_iter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter STEP, default 4, maximum bit positions shifted per BUSY cycle; power of two, 1..XLEN.
REQ-003 Derived localparam SHW = log2(XLEN), shift-amount width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort of any in-flight operation.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 a  input  XLEN  operand (rs1).
REQ-011 shamt  input  SHW  shift amount, already selected upstream (rs2[SHW-1:0] or imm[SHW-1:0]).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  shifted value.
REQ-015 busy  output  1  high in BUSY or DONE.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be high only in IDLE; request accepted on cycle with in_valid && in_ready.
REQ-018 On acceptance the block SHALL capture a, op, shamt into internal registers (data reg, op reg, remaining counter = shamt) and enter BUSY; inputs are don't-care afterwards.
REQ-019 In BUSY with remaining != 0: data reg shifted by k = min(STEP, remaining) per op, remaining decremented by k, stay BUSY.
REQ-020 In BUSY with remaining == 0: enter DONE, no data change.
REQ-021 Per-step semantics: SLL zero-fill from LSB; SRL zero-fill from MSB; SRA fill with current MSB (sign); ROR bits leaving LSB re-enter at MSB.
REQ-022 Latency from acceptance edge to out_valid high SHALL be ceil(shamt/STEP)+1 cycles; shamt=0 yields 1 cycle with result == a.
REQ-023 In DONE, out_valid SHALL be high and result SHALL equal the data reg; result and out_valid held stable while out_ready low.
REQ-024 On out_valid && out_ready the FSM SHALL return to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-025 result SHALL be the data reg in all states; only qualified by out_valid.
REQ-026 flush high SHALL force IDLE on next edge from any state, dropping the operation with no out_valid; flush has priority over acceptance and output handshake in the same cycle.
REQ-027 in_valid while not in_ready SHALL be ignored; no request queuing.
REQ-028 Arithmetic SHALL be full XLEN width; shamt upper bits beyond SHW do not exist at the port (masking is upstream's duty).
REQ-029 Maximum latency SHALL be (XLEN-1)/STEP rounded up +1 cycles (32/4: 9 cycles).

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, data reg = 0, remaining = 0, op reg = 00.
REQ-031 During/after reset: in_ready=1 (once rst_n high), out_valid=0, busy=0, result=0.
REQ-032 Reset asserted mid-operation SHALL discard it; no out_valid produced after release.

Verification (XLEN=32, STEP=4)
REQ-033 SLL a=0x00000005 shamt=2 -> out_valid 2 cycles after accept, result 0x00000014.
REQ-034 SRA a=0xFFFFF000 shamt=4 -> result 0xFFFFFF00 at 2 cycles; SRL same a shamt=31 -> 0x00000001 at 9 cycles.
REQ-035 ROR a=0x00000001 shamt=1 -> 0x80000000; shamt=0 any op, a=0x12345678 -> 0x12345678 after 1 cycle.
REQ-036 out_ready held low 3 cycles in DONE -> out_valid and result unchanged; in_ready stays 0; in_valid pulses ignored.
REQ-037 flush in 2nd BUSY cycle of SRL shamt=31 -> IDLE next edge, out_valid never asserts, next request correct.
REQ-038 rst_n low mid-BUSY -> outputs immediately at reset values; later SLL a=1 shamt=31 -> 0x80000000.
